// File: rtl/lampFPU_pkg.sv
// -----------------------------------------------------------------------------
// lampFPU_pkg
// Shared constants and types for the lampFPU datapath.
//   LAMP_FLOAT_F_DW / LAMP_FLOAT_E_DW / LAMP_FLOAT_E_BIAS : single-format widths
//   sqrtState_t   : control states of the iterative square-root core
//   sqrt_root_w() : root width (hidden + fraction + guard + round) for a
//                   given extended-mantissa width
// -----------------------------------------------------------------------------
package lampFPU_pkg;

    localparam int LAMP_FLOAT_F_DW   = 7;
    localparam int LAMP_FLOAT_E_DW   = 8;
    localparam int LAMP_FLOAT_E_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } sqrtState_t;

    // Extended mantissa already carries the hidden bit; add guard and round.
    function automatic int sqrt_root_w(input int mant_w);
        return mant_w + 2;
    endfunction

endpackage

// File: rtl/lamp_fpu_sqrt_step.sv
// -----------------------------------------------------------------------------
// lamp_fpu_sqrt_step
// One restoring radix-2 square-root iteration (purely combinational).
//   rem       in  ROOT_W+1  partial remainder
//   root      in  ROOT_W    partial root developed so far
//   rad_bits  in  2         next two radicand bits (MSB first)
//   rem_next  out ROOT_W+1  remainder after this step
//   root_bit  out 1         root bit produced by this step
// -----------------------------------------------------------------------------
module lamp_fpu_sqrt_step #(
    parameter int ROOT_W = 10
) (
    input  logic [ROOT_W:0]   rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        rad_bits,
    output logic [ROOT_W:0]   rem_next,
    output logic              root_bit
);

    localparam int REM_W = ROOT_W + 1;

    logic [REM_W+1:0] trial;
    logic [REM_W+1:0] sub;
    logic [REM_W-1:0] diff_lo;

    assign trial = {rem, rad_bits};
    assign sub   = {1'b0, root, 2'b01};

    // The true remainder never exceeds 2*root, so both the kept difference and
    // the restored value fit in REM_W bits; only the compare needs full width.
    assign root_bit = (trial >= sub);
    assign diff_lo  = trial[REM_W-1:0] - sub[REM_W-1:0];
    assign rem_next = root_bit ? diff_lo : trial[REM_W-1:0];

endmodule

// File: rtl/lamp_fpu_sqrt_iter.sv
// -----------------------------------------------------------------------------
// lamp_fpu_sqrt_iter
// Iterative floating-point square root, one root bit per clock.
// Optional feature macro: LAMP_SQRT_SPECIAL_EN (classify zero/negative/Inf/NaN
// operands at accept and bypass the recurrence).
//   clk           in  1          clock, rising edge
//   rst           in  1          synchronous, active-low reset
//   doSqrt_i      in  1          start request, sampled in IDLE only
//   flush_i       in  1          abort; returns to IDLE, no valid_o
//   signum_op_i   in  1          operand sign
//   extExp_op_i   in  EXP_W      biased operand exponent
//   extMant_op_i  in  MANT_W     operand mantissa with hidden bit
//   busy_o        out 1          core not in IDLE
//   valid_o       out 1          one-cycle result strobe
//   s_res_o       out 1          result sign
//   e_res_o       out EXP_W      biased result exponent
//   f_res_o       out ROOT_W+1   {root, sticky}
//   invalid_o     out 1          invalid operation (negative nonzero operand)
// -----------------------------------------------------------------------------
module lamp_fpu_sqrt_iter
    import lampFPU_pkg::*;
#(
    parameter  int MANT_W = 1 + LAMP_FLOAT_F_DW,
    parameter  int EXP_W  = LAMP_FLOAT_E_DW,
    parameter  int BIAS   = LAMP_FLOAT_E_BIAS,
    localparam int ROOT_W = sqrt_root_w(MANT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              doSqrt_i,
    input  logic              flush_i,
    input  logic              signum_op_i,
    input  logic [EXP_W-1:0]  extExp_op_i,
    input  logic [MANT_W-1:0] extMant_op_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic              s_res_o,
    output logic [EXP_W-1:0]  e_res_o,
    output logic [ROOT_W:0]   f_res_o,
    output logic              invalid_o
);

    localparam int                CNT_W   = $clog2(ROOT_W);
    localparam logic [EXP_W:0]    BIAS_X  = BIAS[EXP_W:0];
    localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(ROOT_W - 1);

    sqrtState_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2*ROOT_W-1:0]     rad_q;
    logic [ROOT_W:0]         rem_q;
    logic [ROOT_W-1:0]       root_q;
    logic                    s_q;
    logic [EXP_W-1:0]        e_q;

    logic [ROOT_W:0]         rem_next;
    logic                    root_bit;

    // ---- operand preparation (evaluated at accept) -------------------------
    logic [EXP_W:0]   e_unb;
    logic [EXP_W:0]   e_even;
    logic             odd;
    logic [MANT_W:0]  rad;
    logic [EXP_W-1:0] e_res_new;
    logic             unused_even_lsb;

    assign e_unb     = {1'b0, extExp_op_i} - BIAS_X;
    assign odd       = e_unb[0];
    assign e_even    = e_unb - {{EXP_W{1'b0}}, odd};
    // Bits [EXP_W:1] of the even exponent are its arithmetic half, modulo 2^EXP_W.
    assign e_res_new = e_even[EXP_W:1] + BIAS_X[EXP_W-1:0];
    assign unused_even_lsb = e_even[0];
    // An odd exponent moves one factor of two into the radicand.
    assign rad       = odd ? {extMant_op_i, 1'b0} : {1'b0, extMant_op_i};

`ifdef LAMP_SQRT_SPECIAL_EN
    localparam logic [ROOT_W:0] QNAN_F = {2'b01, {(ROOT_W-1){1'b0}}};

    logic              sp_hit, sp_s, sp_inv;
    logic [EXP_W-1:0]  sp_e;
    logic [ROOT_W:0]   sp_f;
    logic              sp_q, sp_s_q, sp_inv_q, inv_q;
    logic [EXP_W-1:0]  sp_e_q;
    logic [ROOT_W:0]   sp_f_q;
    logic              exp_ones, frac_zero;

    assign exp_ones  = &extExp_op_i;
    assign frac_zero = (extMant_op_i[MANT_W-2:0] == '0);

    always_comb begin
        // NOTE: every variable gets a default before the branches, so no path
        // can leave one unassigned and infer a latch.
        sp_hit = 1'b1;
        sp_s   = 1'b0;
        sp_e   = '0;
        sp_f   = '0;
        sp_inv = 1'b0;
        if (extMant_op_i == '0) begin
            sp_s = signum_op_i;                  // signed zero passes through
        end else if (exp_ones && !frac_zero) begin
            sp_e = '1;                           // NaN in, quiet NaN out
            sp_f = QNAN_F;
        end else if (signum_op_i) begin
            sp_e   = '1;                         // sqrt of a negative number
            sp_f   = QNAN_F;
            sp_inv = 1'b1;
        end else if (exp_ones) begin
            sp_e = '1;                           // +Inf
        end else begin
            sp_hit = 1'b0;
        end
    end

    assign invalid_o = inv_q;
`else
    assign invalid_o = 1'b0;
`endif

    lamp_fpu_sqrt_step #(
        .ROOT_W   (ROOT_W)
    ) u_step (
        .rem      (rem_q),
        .root     (root_q),
        .rad_bits (rad_q[2*ROOT_W-1 -: 2]),
        .rem_next (rem_next),
        .root_bit (root_bit)
    );

    assign busy_o  = (state_q != IDLE);
    assign valid_o = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: datapath registers are cleared too, not just the FSM, so a
            // reset mid-iteration leaves nothing stale on the outputs.
            state_q  <= IDLE;
            cnt_q    <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            s_q      <= 1'b0;
            e_q      <= '0;
            s_res_o  <= 1'b0;
            e_res_o  <= '0;
            f_res_o  <= '0;
`ifdef LAMP_SQRT_SPECIAL_EN
            sp_q     <= 1'b0;
            sp_s_q   <= 1'b0;
            sp_e_q   <= '0;
            sp_f_q   <= '0;
            sp_inv_q <= 1'b0;
            inv_q    <= 1'b0;
`endif
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (doSqrt_i) begin
                        rad_q   <= {rad, {(MANT_W+3){1'b0}}};
                        rem_q   <= '0;
                        root_q  <= '0;
                        cnt_q   <= CNT_TOP;
                        s_q     <= signum_op_i & (extMant_op_i == '0);
                        e_q     <= e_res_new;
`ifdef LAMP_SQRT_SPECIAL_EN
                        sp_q     <= sp_hit;
                        sp_s_q   <= sp_s;
                        sp_e_q   <= sp_e;
                        sp_f_q   <= sp_f;
                        sp_inv_q <= sp_inv;
`endif
                        state_q <= ITER;
                    end
                end
                ITER: begin
`ifdef LAMP_SQRT_SPECIAL_EN
                    // Special operands spend a single cycle here so the
                    // classification is registered before the result is.
                    if (sp_q) begin
                        s_res_o <= sp_s_q;
                        e_res_o <= sp_e_q;
                        f_res_o <= sp_f_q;
                        inv_q   <= sp_inv_q;
                        state_q <= DONE;
                    end else
`endif
                    begin
                        rem_q  <= rem_next;
                        root_q <= {root_q[ROOT_W-2:0], root_bit};
                        rad_q  <= rad_q << 2;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            s_res_o <= s_q;
                            e_res_o <= e_q;
                            f_res_o <= {root_q[ROOT_W-2:0], root_bit, (rem_next != '0)};
`ifdef LAMP_SQRT_SPECIAL_EN
                            inv_q   <= 1'b0;
`endif
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
